aes_input_loader: RTL and testbench



---
 rtl/aes_pkg.sv | 21 ++
 rtl/aes_byte_shifter.sv | 48 ++++
 rtl/aes_input_loader.sv | 161 ++++++++++++++++
 tb/tb_aes_input_loader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared constants and types for the AES input loader: block width, frame-type
// encodings and the loader state enumeration.
package aes_pkg;

  localparam int BLK_W = 128;
  localparam int IN_W  = 8;

  localparam logic [1:0] MODE_KEY = 2'b00;
  localparam logic [1:0] MODE_RSV = 2'b01;
  localparam logic [1:0] MODE_ENC = 2'b10;
  localparam logic [1:0] MODE_DEC = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DROP  = 3'd2,
    ISSUE = 3'd3,
    WAIT  = 3'd4
  } state_e;

endpackage

// File: rtl/aes_byte_shifter.sv
// Beat counter plus MSB-first shift register; exposes the assembled frame
// including the beat currently on din, so the last beat can be captured directly.
module aes_byte_shifter #(
  parameter int BLK_W = 128,
  parameter int IN_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             store,
  input  logic [IN_W-1:0]  din,
  output logic [BLK_W-1:0] frame,
  output logic             last_beat
);
  localparam int NBEATS = BLK_W / IN_W;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BLK_W-1:0] shreg_q, shreg_d;

  assign frame     = {shreg_q[BLK_W-IN_W-1:0], din};
  assign last_beat = (cnt_q == CNT_W'(NBEATS - 1));

  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    if (clr) begin
      cnt_d   = '0;
      shreg_d = '0;
    end else if (en) begin
      // Counter folds back to 0 on the completing beat so IDLE always sees 0.
      cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
      if (store) shreg_d = frame;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: rtl/aes_input_loader.sv
// Assembles key and data frames from a byte stream and issues data blocks to
// the AES core, holding off new input until the core hands the result back.
module aes_input_loader #(
  parameter int BLK_W   = aes_pkg::BLK_W,
  parameter int IN_W    = aes_pkg::IN_W,
  parameter bit WAIT_RY = 1'b1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [IN_W-1:0]  DIn,
  input  logic             DVld,
  output logic             DRdy,
  input  logic [1:0]       Mode,
  input  logic             Abort,
  output logic [BLK_W-1:0] Key,
  output logic             KeyVld,
  output logic [BLK_W-1:0] Data,
  output logic             Sel,
  output logic             Start,
  input  logic             Ack,
  input  logic             Ry,
  output logic             Err
);
  import aes_pkg::*;

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [BLK_W-1:0] key_q, key_d;
  logic [BLK_W-1:0] data_q, data_d;
  logic             keyvld_q, keyvld_d;
  logic             sel_q, sel_d;
  logic             start_q, start_d;
  logic             err_q, err_d;
  logic             drdy_q, drdy_d;

  logic             xfer;
  logic             sh_clr;
  logic             sh_store;
  logic             last_beat;
  logic [BLK_W-1:0] frame;

  // Abort wins over a coincident beat, so the beat never reaches the shifter.
  assign xfer = DVld && drdy_q && !Abort;

  aes_byte_shifter #(
    .BLK_W (BLK_W),
    .IN_W  (IN_W)
  ) u_shift (
    .clk       (Clk),
    .rst_n     (Rst),
    .clr       (sh_clr),
    .en        (xfer),
    .store     (sh_store),
    .din       (DIn),
    .frame     (frame),
    .last_beat (last_beat)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    key_d    = key_q;
    data_d   = data_q;
    keyvld_d = keyvld_q;
    sel_d    = sel_q;
    start_d  = start_q;
    err_d    = err_q;
    sh_clr   = 1'b0;
    sh_store = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          mode_d = Mode;
          if (Mode == MODE_RSV) begin
            err_d   = 1'b1;
            state_d = DROP;
          end else begin
            sh_store = 1'b1;
            state_d  = LOAD;
          end
        end
      end
      LOAD: begin
        sh_store = 1'b1;
        if (Abort) begin
          sh_clr  = 1'b1;
          state_d = IDLE;
        end else if (xfer && last_beat) begin
          if (mode_q == MODE_KEY) begin
            key_d    = frame;
            keyvld_d = 1'b1;
            state_d  = IDLE;
          end else if (!keyvld_q) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            data_d  = frame;
            sel_d   = ~mode_q[0];
            start_d = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      DROP: begin
        if (Abort) begin
          sh_clr  = 1'b1;
          state_d = IDLE;
        end else if (xfer && last_beat) begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (Ack) begin
          start_d = 1'b0;
          state_d = WAIT_RY ? WAIT : IDLE;
        end
      end
      WAIT: begin
        if (Ry) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Registered ready keeps DRdy low while reset is asserted.
    drdy_d = (state_d == IDLE) || (state_d == LOAD) || (state_d == DROP);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= IDLE;
      mode_q   <= MODE_KEY;
      key_q    <= '0;
      data_q   <= '0;
      keyvld_q <= 1'b0;
      sel_q    <= 1'b0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
      drdy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      key_q    <= key_d;
      data_q   <= data_d;
      keyvld_q <= keyvld_d;
      sel_q    <= sel_d;
      start_q  <= start_d;
      err_q    <= err_d;
      drdy_q   <= drdy_d;
    end
  end

  assign DRdy   = drdy_q;
  assign Key    = key_q;
  assign KeyVld = keyvld_q;
  assign Data   = data_q;
  assign Sel    = sel_q;
  assign Start  = start_q;
  assign Err    = err_q;

endmodule

// File: tb/tb_aes_input_loader.sv
// Self-checking bench for aes_input_loader: directed scenarios plus randomized
// frames checked against a frame-level reference model.
module tb_aes_input_loader;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic [7:0]   DIn = '0;
  logic         DVld = 1'b0;
  logic [1:0]   Mode = 2'b00;
  logic         Abort = 1'b0;
  logic         Ack = 1'b0;
  logic         Ry = 1'b0;

  logic         DRdy, KeyVld, Sel, Start, Err;
  logic [127:0] Key, Data;
  logic         DRdy_n, KeyVld_n, Sel_n, Start_n, Err_n;
  logic [127:0] Key_n, Data_n;

  int checks = 0;
  int errors = 0;

  logic [127:0] m_key;
  logic         m_kv;
  logic         m_err;

  always #5 Clk = ~Clk;

  aes_input_loader #(.WAIT_RY(1'b1)) dut (
    .Clk(Clk), .Rst(Rst), .DIn(DIn), .DVld(DVld), .DRdy(DRdy), .Mode(Mode),
    .Abort(Abort), .Key(Key), .KeyVld(KeyVld), .Data(Data), .Sel(Sel),
    .Start(Start), .Ack(Ack), .Ry(Ry), .Err(Err)
  );

  aes_input_loader #(.WAIT_RY(1'b0)) dut_nr (
    .Clk(Clk), .Rst(Rst), .DIn(DIn), .DVld(DVld), .DRdy(DRdy_n), .Mode(Mode),
    .Abort(Abort), .Key(Key_n), .KeyVld(KeyVld_n), .Data(Data_n), .Sel(Sel_n),
    .Start(Start_n), .Ack(Ack), .Ry(Ry), .Err(Err_n)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b0; DVld = 1'b0; Abort = 1'b0; Ack = 1'b0; Ry = 1'b0; Mode = 2'b00;
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    m_key = '0; m_kv = 1'b0; m_err = 1'b0;
  endtask

  // Presents one byte and waits (bounded) until it is taken; returns on a negedge.
  task automatic drive_beat(input logic [7:0] b, input logic [1:0] m);
    int n = 0;
    DIn = b; Mode = m; DVld = 1'b1;
    while (DRdy !== 1'b1 && n < 40) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 40) begin
      errors++;
      $display("FAIL beat_accept: DRdy=%b after %0d cycles, required 1", DRdy, n);
    end
    @(negedge Clk);
    DVld = 1'b0;
  endtask

  // Sends a full frame MSB first; only the first beat carries the real Mode.
  task automatic send_frame(input logic [1:0] m, input logic [127:0] f, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge Clk);
      drive_beat(f[127 - 8*i -: 8], (i == 0) ? m : 2'($urandom));
    end
  endtask

  // Ack after ack_dly cycles (Ry noise meanwhile), then Ry after ry_dly cycles (Ack noise).
  task automatic complete_issue(input int ack_dly, input int ry_dly);
    repeat (ack_dly) begin Ry = 1'($urandom); @(negedge Clk); end
    Ry = 1'b0; Ack = 1'b1;
    @(negedge Clk);
    Ack = 1'b0;
    repeat (ry_dly) begin Ack = 1'($urandom); @(negedge Clk); end
    Ack = 1'b0; Ry = 1'b1;
    @(negedge Clk);
    Ry = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clk);
    checks++; if (DRdy !== 1'b0) begin errors++; $display("FAIL rst_drdy_in_reset got=%b exp=0", DRdy); end
    checks++; if ({Key, Data} !== 256'd0) begin errors++; $display("FAIL rst_key_data got=%h/%h exp=0", Key, Data); end
    checks++; if ({KeyVld, Sel, Start, Err} !== 4'b0) begin errors++; $display("FAIL rst_flags got=%b exp=0000", {KeyVld, Sel, Start, Err}); end
    Rst = 1'b1;
    @(negedge Clk);
    checks++; if (DRdy !== 1'b1) begin errors++; $display("FAIL rst_drdy_after got=%b exp=1", DRdy); end
    checks++; if (dut.u_shift.cnt_q !== 4'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", dut.u_shift.cnt_q); end
    m_key = '0; m_kv = 1'b0; m_err = 1'b0;
  endtask

  task automatic test_key_encrypt();
    logic [127:0] kf, df;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      kf[127 - 8*i -: 8] = 8'(i);
      df[127 - 8*i -: 8] = 8'(i * 8'h11);
    end
    send_frame(2'b00, kf, 1'b0);
    checks++; if (Key !== 128'h000102030405060708090a0b0c0d0e0f) begin errors++; $display("FAIL ke_key got=%h", Key); end
    checks++; if (KeyVld !== 1'b1 || Start !== 1'b0) begin errors++; $display("FAIL ke_keyvld got kv=%b start=%b exp 1/0", KeyVld, Start); end
    send_frame(2'b10, df, 1'b0);
    checks++; if (Data !== 128'h00112233445566778899aabbccddeeff) begin errors++; $display("FAIL ke_data got=%h", Data); end
    checks++; if (Start !== 1'b1 || Sel !== 1'b1 || DRdy !== 1'b0) begin errors++; $display("FAIL ke_issue got start=%b sel=%b drdy=%b exp 1/1/0", Start, Sel, DRdy); end
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      checks++; if (Start !== 1'b1 || Data !== 128'h00112233445566778899aabbccddeeff) begin errors++; $display("FAIL ke_hold%0d start=%b data=%h", c, Start, Data); end
    end
    Ack = 1'b1;
    @(negedge Clk);
    Ack = 1'b0;
    checks++; if (Start !== 1'b0 || DRdy !== 1'b0) begin errors++; $display("FAIL ke_ack got start=%b drdy=%b exp 0/0", Start, DRdy); end
    checks++; if (DRdy_n !== 1'b1) begin errors++; $display("FAIL nory_drdy got=%b exp=1", DRdy_n); end
    DVld = 1'b1; DIn = 8'($urandom);
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      checks++; if (DRdy !== 1'b0 || Data !== 128'h00112233445566778899aabbccddeeff || Sel !== 1'b1) begin errors++; $display("FAIL ry_gate%0d drdy=%b sel=%b exp 0/1", c, DRdy, Sel); end
    end
    Ry = 1'b1;
    @(negedge Clk);
    Ry = 1'b0; DVld = 1'b0;
    checks++; if (DRdy !== 1'b1) begin errors++; $display("FAIL ry_release got=%b exp=1", DRdy); end
    $display("txn key_encrypt done");
  endtask

  task automatic test_no_key();
    logic [127:0] f, k;
    do_reset();
    f = {$urandom, $urandom, $urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    send_frame(2'b11, f, 1'b1);
    checks++; if (Err !== 1'b1 || Start !== 1'b0) begin errors++; $display("FAIL nokey_err got err=%b start=%b exp 1/0", Err, Start); end
    checks++; if (DRdy !== 1'b1 || Data !== 128'd0) begin errors++; $display("FAIL nokey_idle got drdy=%b data=%h exp 1/0", DRdy, Data); end
    send_frame(2'b00, k, 1'b1);
    send_frame(2'b11, f, 1'b1);
    checks++; if (Start !== 1'b1 || Sel !== 1'b0 || Data !== f) begin errors++; $display("FAIL dec_issue start=%b sel=%b data=%h exp 1/0/%h", Start, Sel, Data, f); end
    checks++; if (Err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", Err); end
    complete_issue(1, 1);
    $display("txn no_key done");
  endtask

  task automatic test_abort();
    logic [127:0] k1;
    do_reset();
    k1 = {$urandom, $urandom, $urandom, $urandom};
    send_frame(2'b00, k1, 1'b0);
    for (int i = 0; i < 7; i++) drive_beat(8'($urandom), 2'b00);
    Abort = 1'b1;
    @(negedge Clk);
    Abort = 1'b0;
    checks++; if (Key !== k1 || KeyVld !== 1'b1) begin errors++; $display("FAIL abort_key got=%h kv=%b exp=%h", Key, KeyVld, k1); end
    checks++; if (dut.u_shift.cnt_q !== 4'd0 || DRdy !== 1'b1) begin errors++; $display("FAIL abort_cnt got cnt=%0d drdy=%b exp 0/1", dut.u_shift.cnt_q, DRdy); end
    for (int i = 0; i < 3; i++) drive_beat(8'($urandom), 2'b00);
    Abort = 1'b1; DVld = 1'b1; DIn = 8'hA5;
    @(negedge Clk);
    Abort = 1'b0; DVld = 1'b0;
    checks++; if (dut.u_shift.cnt_q !== 4'd0) begin errors++; $display("FAIL abort_xfer_cnt got=%0d exp=0", dut.u_shift.cnt_q); end
    send_frame(2'b00, 128'h03c18e199ba5296289328eca914a59aa, 1'b1);
    checks++; if (Key !== 128'h03c18e199ba5296289328eca914a59aa) begin errors++; $display("FAIL abort_reload got=%h", Key); end
    $display("txn abort done");
  endtask

  task automatic test_reserved();
    logic [127:0] k;
    do_reset();
    k = {$urandom, $urandom, $urandom, $urandom};
    send_frame(2'b01, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    checks++; if (Err !== 1'b1 || KeyVld !== 1'b0 || Key !== 128'd0 || DRdy !== 1'b1) begin errors++; $display("FAIL rsv_drop err=%b kv=%b drdy=%b exp 1/0/1", Err, KeyVld, DRdy); end
    send_frame(2'b00, k, 1'b1);
    checks++; if (Key !== k || KeyVld !== 1'b1) begin errors++; $display("FAIL rsv_next_key got=%h exp=%h", Key, k); end
    $display("txn reserved done");
  endtask

  task automatic test_async_reset();
    logic [127:0] f;
    do_reset();
    f = {$urandom, $urandom, $urandom, $urandom};
    send_frame(2'b00, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    send_frame(2'b10, f, 1'b0);
    Ack = 1'b1;
    @(negedge Clk);
    Ack = 1'b0;
    #2 Rst = 1'b0;
    #1;
    checks++; if ({Key, Data} !== 256'd0) begin errors++; $display("FAIL arst_key_data got=%h/%h exp=0", Key, Data); end
    checks++; if ({DRdy, KeyVld, Sel, Start, Err} !== 5'b0) begin errors++; $display("FAIL arst_flags got=%b exp=00000", {DRdy, KeyVld, Sel, Start, Err}); end
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    m_key = '0; m_kv = 1'b0; m_err = 1'b0;
    $display("txn async_reset done");
  endtask

  task automatic test_random();
    logic [127:0] f;
    logic [1:0]   m;
    int           kind, k;
    bit           exp_start;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      f = {$urandom, $urandom, $urandom, $urandom};
      kind = $urandom_range(0, 9);
      m = (kind < 3) ? 2'b00 : (kind < 5) ? 2'b10 : (kind < 7) ? 2'b11 :
          (kind == 7) ? 2'b01 : ($urandom_range(0, 1) ? 2'b00 : 2'b10);
      if (kind >= 8) begin
        k = $urandom_range(1, 15);
        for (int i = 0; i < k; i++) drive_beat(f[127 - 8*i -: 8], (i == 0) ? m : 2'($urandom));
        Abort = 1'b1; DVld = 1'b1; DIn = 8'($urandom);
        @(negedge Clk);
        Abort = 1'b0; DVld = 1'b0;
        $display("txn %0d abort after %0d beats mode=%b", n, k, m);
        checks++; if (dut.u_shift.cnt_q !== 4'd0 || DRdy !== 1'b1) begin errors++; $display("FAIL rnd_abort cnt=%0d drdy=%b exp 0/1", dut.u_shift.cnt_q, DRdy); end
      end else begin
        send_frame(m, f, 1'b1);
        exp_start = 1'b0;
        if (m == 2'b01) m_err = 1'b1;
        else if (m == 2'b00) begin m_key = f; m_kv = 1'b1; end
        else if (!m_kv) m_err = 1'b1;
        else exp_start = 1'b1;
        $display("txn %0d frame mode=%b data=%h issue=%0d", n, m, f, exp_start);
        checks++; if (Start !== exp_start) begin errors++; $display("FAIL rnd_start got=%b exp=%b", Start, exp_start); end
        if (exp_start) begin
          checks++; if (Data !== f || Sel !== (m == 2'b10)) begin errors++; $display("FAIL rnd_data got=%h sel=%b exp=%h/%b", Data, Sel, f, (m == 2'b10)); end
          complete_issue($urandom_range(0, 4), $urandom_range(0, 4));
          checks++; if (DRdy !== 1'b1 || Start !== 1'b0) begin errors++; $display("FAIL rnd_release drdy=%b start=%b exp 1/0", DRdy, Start); end
        end else begin
          checks++; if (DRdy !== 1'b1) begin errors++; $display("FAIL rnd_drdy got=%b exp=1", DRdy); end
        end
      end
      checks++; if (Key !== m_key || KeyVld !== m_kv) begin errors++; $display("FAIL rnd_key got=%h/%b exp=%h/%b", Key, KeyVld, m_key, m_kv); end
      checks++; if (Err !== m_err) begin errors++; $display("FAIL rnd_err got=%b exp=%b", Err, m_err); end
      checks++; if (Key_n !== m_key) begin errors++; $display("FAIL rnd_key_nory got=%h exp=%h", Key_n, m_key); end
    end
  endtask

  initial begin
    test_reset();
    test_key_encrypt();
    test_no_key();
    test_abort();
    test_reserved();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
